// File: rtl/eater_core.sv
// eater_core: parametrised SAP-1 style 8-bit computer (RAM, PC, A/B, ALU, IR, 5-step sequencer, OUT).
// Optional RAM readback port is enabled by defining EATER_CORE_READBACK_EN.
module eater_core #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 4,
   parameter int CLK_DIV = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prog_mode,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   input  logic              prog_we,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              halted,
   output logic              carry,
   output logic              zero,
   output logic [ADDR_W-1:0] pc
`ifdef EATER_CORE_READBACK_EN
   ,
   output logic [DATA_W-1:0] prog_rdata
`endif
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } step_e;

   step_e             step_q, step_d;
   logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, ir_q, ir_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              carry_q, carry_d, zero_q, zero_d;
   logic              halted_q, halted_d, out_valid_q, out_valid_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DATA_W-1:0] ram_q [2**ADDR_W];

   logic              tick_s;
   logic [3:0]        opcode_s;
   logic [ADDR_W-1:0] operand_s;
   logic [DATA_W-1:0] imm_s, ram_rd_s;
   logic [DATA_W:0]   alu_s;
   logic              ram_we_s;
   logic [ADDR_W-1:0] ram_waddr_s;
   logic [DATA_W-1:0] ram_wdata_s;

   assign tick_s    = !prog_mode && !halted_q && (div_q == DIV_LAST);
   assign opcode_s  = ir_q[DATA_W-1 -: 4];
   assign operand_s = ir_q[ADDR_W-1:0];
   assign imm_s     = DATA_W'(ir_q[DATA_W-5:0]);
   assign ram_rd_s  = ram_q[mar_q];

   // ALU: subtraction is A + ~B + 1 so carry-out means "no borrow"
   always_comb begin
      alu_s = '0;
      if (opcode_s == OP_SUB) begin
         alu_s = {1'b0, a_q} + {1'b0, ~b_q} + {{DATA_W{1'b0}}, 1'b1};
      end else begin
         alu_s = {1'b0, a_q} + {1'b0, b_q};
      end
   end

   // Next-state: programming clears the core, otherwise one microstep per tick
   always_comb begin
      step_d      = step_q;
      pc_d        = pc_q;
      mar_d       = mar_q;
      a_d         = a_q;
      b_d         = b_q;
      ir_d        = ir_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      halted_d    = halted_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      div_d       = div_q;
      ram_we_s    = 1'b0;
      ram_waddr_s = prog_addr;
      ram_wdata_s = prog_data;
      if (prog_mode) begin
         step_d   = T0;
         pc_d     = '0;
         mar_d    = '0;
         a_d      = '0;
         b_d      = '0;
         ir_d     = '0;
         carry_d  = 1'b0;
         zero_d   = 1'b0;
         halted_d = 1'b0;
         div_d    = '0;
         ram_we_s = prog_we;
      end else if (tick_s) begin
         div_d = '0;
         case (step_q)
            T0: begin
               mar_d  = pc_q;
               step_d = T1;
            end
            T1: begin
               ir_d   = ram_rd_s;
               pc_d   = pc_q + ADDR_W'(1);
               step_d = T2;
            end
            T2: begin
               step_d = T3;
               case (opcode_s)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_d = operand_s;
                  OP_LDI: a_d = imm_s;
                  OP_JMP: pc_d = operand_s;
                  OP_JC:  pc_d = carry_q ? operand_s : pc_q;
                  OP_JZ:  pc_d = zero_q ? operand_s : pc_q;
                  OP_OUT: begin
                     out_data_d  = a_q;
                     out_valid_d = 1'b1;
                  end
                  OP_HLT: begin
                     halted_d = 1'b1;
                     step_d   = T2;
                  end
                  default: step_d = T3;
               endcase
            end
            T3: begin
               step_d = T4;
               case (opcode_s)
                  OP_LDA:         a_d = ram_rd_s;
                  OP_ADD, OP_SUB: b_d = ram_rd_s;
                  OP_STA: begin
                     ram_we_s    = 1'b1;
                     ram_waddr_s = mar_q;
                     ram_wdata_s = a_q;
                  end
                  default: step_d = T4;
               endcase
            end
            T4: begin
               step_d = T0;
               if ((opcode_s == OP_ADD) || (opcode_s == OP_SUB)) begin
                  a_d     = alu_s[DATA_W-1:0];
                  carry_d = alu_s[DATA_W];
                  zero_d  = (alu_s[DATA_W-1:0] == '0);
               end else begin
                  a_d = a_q;
               end
            end
            default: step_d = T0;
         endcase
      end else if (!halted_q) begin
         div_d = div_q + DIV_W'(1);
      end else begin
         div_d = div_q;
      end
   end

   // Core state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q      <= T0;
         pc_q        <= '0;
         mar_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         ir_q        <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         halted_q    <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         div_q       <= '0;
      end else begin
         step_q      <= step_d;
         pc_q        <= pc_d;
         mar_q       <= mar_d;
         a_q         <= a_d;
         b_q         <= b_d;
         ir_q        <= ir_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         halted_q    <= halted_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         div_q       <= div_d;
      end
   end

   // Program RAM keeps its contents across reset
   always_ff @(posedge clk) begin
      if (ram_we_s) begin
         ram_q[ram_waddr_s] <= ram_wdata_s;
      end
   end

`ifdef EATER_CORE_READBACK_EN
   logic [DATA_W-1:0] rdata_q, rdata_d;

   always_comb begin
      if (ram_we_s && (ram_waddr_s == prog_addr)) begin
         rdata_d = ram_wdata_s;
      end else begin
         rdata_d = ram_q[prog_addr];
      end
   end

   // Readback register, bypassed with same-cycle write data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign prog_rdata = rdata_q;
`endif

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign halted    = halted_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign pc        = pc_q;

endmodule

// File: tb/tb_eater_core.sv
// Bench for eater_core: two instances (CLK_DIV=1 and CLK_DIV=4) share stimulus and are
// checked against an instruction-level reference model of the SAP-1 ISA.
module tb_eater_core;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       prog_mode;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;
   logic       prog_we;

   logic [7:0] o1_data, o4_data;
   logic       o1_valid, o4_valid, o1_halt, o4_halt, o1_c, o4_c, o1_z, o4_z;
   logic [3:0] o1_pc, o4_pc;
`ifdef EATER_CORE_READBACK_EN
   logic [7:0] o1_rdata, o4_rdata;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] img [16];
   int m_ov [0:127];
   int m_od [0:127];
   int s_pc [0:127];
   int s_c  [0:127];
   int s_z  [0:127];
   int s_h  [0:127];
   int last1 = 0;
   int last4 = 0;

   eater_core #(.DATA_W(8), .ADDR_W(4), .CLK_DIV(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .prog_mode(prog_mode), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_we(prog_we), .out_data(o1_data), .out_valid(o1_valid),
      .halted(o1_halt), .carry(o1_c), .zero(o1_z), .pc(o1_pc)
`ifdef EATER_CORE_READBACK_EN
      , .prog_rdata(o1_rdata)
`endif
   );

   eater_core #(.DATA_W(8), .ADDR_W(4), .CLK_DIV(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .prog_mode(prog_mode), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_we(prog_we), .out_data(o4_data), .out_valid(o4_valid),
      .halted(o4_halt), .carry(o4_c), .zero(o4_z), .pc(o4_pc)
`ifdef EATER_CORE_READBACK_EN
      , .prog_rdata(o4_rdata)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Instruction-level ISA model: s_* = architectural state after k instructions.
   task automatic model_run(input int ni);
      int mem [16];
      int a, pcm, c, z, h, ir, op, opnd, r;
      for (int i = 0; i < 16; i++) mem[i] = int'(img[i]);
      a = 0; pcm = 0; c = 0; z = 0; h = 0;
      for (int k = 0; k < ni; k++) begin
         s_pc[k] = pcm; s_c[k] = c; s_z[k] = z; s_h[k] = h;
         m_ov[k] = 0; m_od[k] = 0;
         if (h == 0) begin
            ir   = mem[pcm];
            pcm  = (pcm + 1) % 16;
            op   = ir / 16;
            opnd = ir % 16;
            case (op)
               1: a = mem[opnd];
               2: begin r = a + mem[opnd]; c = r / 256; a = r % 256; z = (a == 0) ? 1 : 0; end
               3: begin r = a + (255 - mem[opnd]) + 1; c = r / 256; a = r % 256; z = (a == 0) ? 1 : 0; end
               4: mem[opnd] = a;
               5: a = opnd;
               6: pcm = opnd;
               7: if (c != 0) pcm = opnd;
               8: if (z != 0) pcm = opnd;
               14: begin m_ov[k] = 1; m_od[k] = a; end
               15: h = 1;
               default: r = 0;
            endcase
         end
      end
      s_pc[ni] = pcm; s_c[ni] = c; s_z[ni] = z; s_h[ni] = h;
   endtask

   task automatic load_prog();
      @(negedge clk);
      prog_mode = 1'b1;
      for (int i = 0; i < 16; i++) begin
         prog_we   = 1'b1;
         prog_addr = 4'(i);
         prog_data = img[i];
         @(negedge clk);
      end
      prog_we = 1'b0;
      chk("hold_out1", 32'(o1_data), 32'(last1));
      chk("hold_out4", 32'(o4_data), 32'(last4));
      chk("prog_pc1", 32'(o1_pc), 32'd0);
      chk("prog_halt4", 32'(o4_halt), 32'd0);
   endtask

   // Runs 20*k edges: the div-1 core covers 4*k instructions, the div-4 core k instructions.
   task automatic run_check(input int k, input bit junk);
      int e, t, x;
      logic ev;
      model_run(4 * k);
      e = 20 * k;
      prog_mode = 1'b0;
      for (int j = 1; j <= e; j++) begin
         if (junk) begin
            prog_we   = 1'($urandom_range(0, 1));
            prog_addr = 4'($urandom_range(0, 15));
            prog_data = 8'($urandom_range(0, 255));
         end else begin
            prog_we = 1'b0;
         end
         @(negedge clk);
         x  = (j >= 3 && (j - 3) % 5 == 0) ? m_ov[(j - 3) / 5] : 0;
         ev = (x != 0);
         chk("out_valid1", 32'(o1_valid), 32'(ev));
         if (ev) begin
            chk("out_data1", 32'(o1_data), 32'(m_od[(j - 3) / 5]));
            last1 = m_od[(j - 3) / 5];
         end
         if (j % 5 == 0) begin
            chk("pc1", 32'(o1_pc), 32'(s_pc[j / 5]));
            chk("carry1", 32'(o1_c), 32'(s_c[j / 5]));
            chk("zero1", 32'(o1_z), 32'(s_z[j / 5]));
            chk("halted1", 32'(o1_halt), 32'(s_h[j / 5]));
         end
         ev = 1'b0;
         t  = j / 4;
         if (j % 4 == 0 && t >= 3 && (t - 3) % 5 == 0) ev = (m_ov[(t - 3) / 5] != 0);
         chk("out_valid4", 32'(o4_valid), 32'(ev));
         if (ev) begin
            chk("out_data4", 32'(o4_data), 32'(m_od[(t - 3) / 5]));
            last4 = m_od[(t - 3) / 5];
         end
         if (j % 20 == 0) begin
            chk("pc4", 32'(o4_pc), 32'(s_pc[j / 20]));
            chk("carry4", 32'(o4_c), 32'(s_c[j / 20]));
            chk("zero4", 32'(o4_z), 32'(s_z[j / 20]));
            chk("halted4", 32'(o4_halt), 32'(s_h[j / 20]));
         end
      end
      prog_we = 1'b0;
   endtask

   task automatic set_add_prog();
      for (int i = 0; i < 16; i++) img[i] = 8'h00;
      img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
      img[14] = 8'd28; img[15] = 8'd14;
   endtask

   initial begin
      rst_n = 1'b0; prog_mode = 1'b1; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 8'd0;
      @(negedge clk);
      chk("rst_out_data", 32'(o1_data), 32'd0);
      chk("rst_out_valid", 32'(o1_valid), 32'd0);
      chk("rst_halted", 32'(o4_halt), 32'd0);
      chk("rst_carry", 32'(o1_c), 32'd0);
      chk("rst_zero", 32'(o4_z), 32'd0);
      chk("rst_pc", 32'(o1_pc), 32'd0);
      rst_n = 1'b1;

      // add program: 28 + 14 = 42, OUT lands on edge 13 (div 1) / 52 (div 4)
      set_add_prog();
      load_prog();
      run_check(4, 1'b0);
      chk("add_out", 32'(o1_data), 32'd42);
      chk("add_pc", 32'(o4_pc), 32'd4);
      chk("add_halt", 32'(o4_halt), 32'd1);

      // prog_we in run mode must not touch RAM
      load_prog();
      run_check(4, 1'b1);
      chk("junk_out", 32'(o4_data), 32'd42);

      // subtract with borrow, JC not taken
      for (int i = 0; i < 16; i++) img[i] = 8'h00;
      img[0] = 8'h53; img[1] = 8'h3F; img[2] = 8'h70; img[3] = 8'hE0; img[4] = 8'hF0;
      img[15] = 8'h05;
      load_prog();
      run_check(5, 1'b0);
      chk("sub_out", 32'(o1_data), 32'hFE);
      chk("sub_carry", 32'(o4_c), 32'd0);

      // overflow to zero, JZ taken
      for (int i = 0; i < 16; i++) img[i] = 8'hF0;
      img[0] = 8'h5F; img[1] = 8'h2F; img[2] = 8'h86; img[6] = 8'hE0; img[7] = 8'hF0;
      img[15] = 8'hF1;
      load_prog();
      run_check(5, 1'b0);
      chk("ovf_out", 32'(o4_data), 32'd0);
      chk("ovf_carry", 32'(o1_c), 32'd1);
      chk("ovf_zero", 32'(o4_z), 32'd1);

      // all NOPs: PC wraps, no output, never halts
      for (int i = 0; i < 16; i++) img[i] = 8'h00;
      load_prog();
      run_check(5, 1'b0);
      chk("wrap_halt", 32'(o1_halt), 32'd0);

      // reset mid-T3 of ADD on the div-1 core, then a clean re-run
      set_add_prog();
      load_prog();
      prog_mode = 1'b0;
      for (int j = 0; j < 8; j++) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_out", 32'(o1_data), 32'd0);
      chk("mid_rst_pc", 32'(o1_pc), 32'd0);
      chk("mid_rst_halt", 32'(o1_halt), 32'd0);
      chk("mid_rst_valid", 32'(o1_valid), 32'd0);
      last1 = 0; last4 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      run_check(4, 1'b0);
      chk("rerun_out", 32'(o1_data), 32'd42);

      // random programs
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
         load_prog();
         run_check(6, 1'b1);
      end

`ifdef EATER_CORE_READBACK_EN
      @(negedge clk);
      prog_mode = 1'b1; prog_we = 1'b1; prog_addr = 4'd9; prog_data = 8'hA5;
      @(negedge clk);
      prog_we = 1'b0;
      chk("rdata_wr", 32'(o1_rdata), 32'hA5);
      @(negedge clk);
      chk("rdata_rd", 32'(o4_rdata), 32'hA5);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/eater_core.md
# eater_core

Parametrised successor to the `eightBit` SAP-1 style core behind the `tt_um_eater_8bit` TinyTapeout wrapper. It contains program RAM, PC, A/B registers, ALU with carry/zero flags, instruction register, a 5-step microsequencer and an output register. The data width, address width and execution clock divider are configurable. Programming mode loads RAM over a parallel port, and releasing it starts execution at address 0.

## Interface
- `DATA_W`, default 8: data/instruction width. Must be ≥ 4 + `ADDR_W`.
- `ADDR_W`, default 4: RAM address width. RAM depth is 2^`ADDR_W`.
- `CLK_DIV`, default 1: execution tick period in `clk` cycles. Must be ≥ 1.

- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `prog_mode`  in  1  1 = hold core and accept RAM writes; 0 = run.
- `prog_addr`  in  `ADDR_W`  RAM write address.
- `prog_data`  in  `DATA_W`  RAM write data.
- `prog_we`  in  1  RAM write strobe. Honoured only when `prog_mode`=1.
- `out_data`  out  `DATA_W`  OUT register.
- `out_valid`  out  1  one-`clk` pulse when OUT executes.
- `halted`  out  1  HLT executed.
- `carry`  out  1  carry flag.
- `zero`  out  1  zero flag.
- `pc`  out  `ADDR_W`  program counter.

## Operation
- Instruction format:
  - opcode = bits [`DATA_W`-1:`DATA_W`-4].
  - operand = bits [`ADDR_W`-1:0].
  - immediate = bits [`DATA_W`-5:0], zero-extended.
- Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, E OUT, F HLT. Opcodes 9–D behave as NOP.
- Every instruction takes 5 steps, T0–T4. One step advances per tick.
  - T0: MAR←PC.
  - T1: IR←RAM[MAR], PC←PC+1.
- Execute steps (steps not listed are idle):
  - LDA: T2 MAR←operand; T3 A←RAM[MAR].
  - ADD/SUB: T2 MAR←operand; T3 B←RAM[MAR]; T4 A←A±B, flags updated.
  - STA: T2 MAR←operand; T3 RAM[MAR]←A.
  - LDI: T2 A←immediate.
  - JMP: T2 PC←operand.
  - JC / JZ: T2 PC←operand only if the flag is set.
  - OUT: T2 out_data←A, `out_valid` pulses.
  - HLT: T2 `halted`←1. Sequencer freezes and does not complete the instruction.
- Arithmetic:
  - ADD: {carry,A} = A+B, computed at `DATA_W`+1 bits.
  - SUB: A + ~B + 1. carry = carry-out, so 1 means no borrow.
  - zero = (result == 0).
  - Only ADD and SUB alter the flags.
- RAM read is asynchronous from MAR. RAM write is synchronous. RAM is not cleared by reset.
- PC increment wraps modulo 2^`ADDR_W`.
- `prog_mode`=1, checked every `clk`:
  - Synchronously clears PC, MAR, step, A, B, IR, flags, `halted`, `out_valid` and the tick divider.
  - `out_data` is retained.
  - `prog_we`=1 writes RAM[`prog_addr`]←`prog_data`.
- `prog_we` while `prog_mode`=0 is ignored.
- Halted state: exits only via `prog_mode` or reset.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `halted`=0, `carry`=0, `zero`=0, `pc`=0. Step=T0, divider=0.
- Reset asserted mid-instruction aborts immediately. On release, execution restarts from T0 at PC=0 if `prog_mode`=0. RAM is unaffected.
- Tick generation:
  - A tick fires on every `CLK_DIV`-th `clk` edge with `prog_mode`=0 and `halted`=0.
  - The first tick is the `CLK_DIV`-th edge after `prog_mode` falls or reset releases.
  - With `CLK_DIV`=1, every edge is a tick.
- All register updates occur on tick edges only. Exception: RAM writes in programming mode happen on any edge.
- `out_valid` is high for exactly one `clk` after the OUT T2 edge, regardless of `CLK_DIV`.
- Programming-mode write is visible to a run started on the next cycle.
- Simultaneous `prog_mode` rise and tick: `prog_mode` wins, and no step executes.

## Configuration
- `EATER_CORE_READBACK_EN`
  - Defined: adds output `prog_rdata`, width `DATA_W`, equal to RAM[`prog_addr`] registered with 1-`clk` latency in any mode. A same-cycle write returns the new data. Reset value 0.
  - Undefined: the port and its register are absent, and RAM has no second read port.

## Test plan
- Add program, `CLK_DIV`=1:
  - Program RAM[0..3]=1E,2F,E0,F0 and RAM[14]=28, RAM[15]=14, then drop `prog_mode`.
  - Expect `out_valid` on edge 13 with `out_data`=42, then `halted`=1, carry=0, zero=0, `pc`=4.
- Subtract with borrow:
  - Program LDI 3; SUB 15 with RAM[15]=5; JC 0; OUT; HLT.
  - Expect A=0xFE, carry=0, JC not taken, `out_data`=0xFE.
- Overflow and conditional jump:
  - Program LDI 15; ADD with RAM=0xF1; JZ 6; at 6 OUT, HLT.
  - Expect carry=1, zero=1, jump taken, `out_data`=0.
- PC wrap:
  - Fill all 16 words with NOP and run.
  - Expect `pc` sequence 1..15,0,1 at 5-tick spacing; no `out_valid`, `halted`=0.
- Divider and control:
  - Use `CLK_DIV`=4 with the add program; expect `out_valid` on edge 52.
  - Assert `prog_we` in run mode; expect RAM unchanged.
  - Assert `rst_n` low mid-T3; expect all outputs at reset values and the program to re-execute from PC 0.
- Readback (macro defined):
  - Write 0xA5 to address 9, then read address 9.
  - Expect `prog_rdata`=0xA5 one `clk` later.
